// File: rtl/arith_seq.sv
// arith_seq -- sequential multi-cycle arithmetic unit.
//
// One operation at a time: a request is accepted in IDLE, iterates in CALC,
// and presents its result with a one-cycle done pulse in FIN.
//
// Opcodes: 0 SUM, 1 SUB, 2 MUL, 3 DIV, 4 SQRT, 5 POW; all others undefined
// (result 0, err 1).
//
// Optional feature: define ARITH_SQRT_EN to build the square-root datapath.
// Without it, the SQRT opcode behaves like any undefined opcode.
//
// Ports:
//   CLK     in   sole clock, rising edge
//   RST     in   synchronous active-high reset
//   start   in   request, sampled only in IDLE
//   opcode  in   [3:0] operation select
//   a, b    in   [WIDTH-1:0] unsigned operands
//   busy    out  high from the cycle after accept through the done cycle
//   done    out  one-cycle pulse, result/err valid
//   result  out  [OUTW-1:0] registered result, held afterwards
//   err     out  error flag, qualified by done, held with result
//
// WIDTH must be even and >= 4; OUTW must equal 2*WIDTH.

module arith_seq #(
  parameter int WIDTH = 32,
  parameter int OUTW  = 2 * WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [OUTW-1:0]  result,
  output logic             err
);

  localparam logic [3:0] OP_SUM  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SQRT = 4'd4;
  localparam logic [3:0] OP_POW  = 4'd5;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH - 1);
`ifdef ARITH_SQRT_EN
  localparam logic [CW-1:0] CNT_HALF = CW'(WIDTH / 2 - 1);
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state, state_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc_a;     // operand A; dividend/quotient shifter for DIV, radicand shifter for SQRT
  logic [WIDTH-1:0] acc_b;     // operand B; exponent shifter for POW
  logic [WIDTH:0]   div_rem;   // partial remainder shared by DIV and SQRT
  logic [OUTW-1:0]  pow_res;
  logic [OUTW-1:0]  pow_base;
  logic             base_ovf;  // true value of pow_base no longer fits OUTW bits
  logic             err_acc;   // an overflowing factor has entered pow_res
  logic [CW-1:0]    cnt;
`ifdef ARITH_SQRT_EN
  logic [WIDTH-1:0] acc_q;     // square root built one bit per iteration
`endif

  logic             last_iter;
  logic [OUTW-1:0]  a_ext, b_ext;
  logic [WIDTH:0]   rem_sh, div_rem_nxt;
  logic             div_ge;
  logic [WIDTH-1:0] quot_nxt;
  logic [2*OUTW-1:0] pow_mul, pow_sq;
  logic [OUTW-1:0]  pow_res_nxt;
  logic             base_ovf_nxt, err_acc_nxt;
  logic [OUTW-1:0]  calc_result;
  logic             calc_err;
`ifdef ARITH_SQRT_EN
  logic [WIDTH:0]   sq_sh, sq_trial, sq_rem_nxt;
  logic             sq_ge;
  logic [WIDTH-1:0] root_nxt;
`endif

  assign last_iter = (cnt == '0);
  assign a_ext = {{(OUTW-WIDTH){1'b0}}, acc_a};
  assign b_ext = {{(OUTW-WIDTH){1'b0}}, acc_b};

  // Restoring division step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits, and shift the quotient bit into acc_a.
  assign rem_sh      = (div_rem << 1) | {{WIDTH{1'b0}}, acc_a[WIDTH-1]};
  assign div_ge      = (rem_sh >= {1'b0, acc_b});
  assign div_rem_nxt = div_ge ? (rem_sh - {1'b0, acc_b}) : rem_sh;
  assign quot_nxt    = {acc_a[WIDTH-2:0], div_ge};

  // Square-and-multiply step, LSB of the exponent first. A base that has
  // overflowed only matters once it is actually multiplied in, so err tracks
  // whether the true power exceeds OUTW bits.
  assign pow_mul      = {{OUTW{1'b0}}, pow_res} * {{OUTW{1'b0}}, pow_base};
  assign pow_sq       = {{OUTW{1'b0}}, pow_base} * {{OUTW{1'b0}}, pow_base};
  assign pow_res_nxt  = acc_b[0] ? pow_mul[OUTW-1:0] : pow_res;
  assign base_ovf_nxt = base_ovf | (pow_sq[2*OUTW-1:OUTW] != '0);
  assign err_acc_nxt  = err_acc | (acc_b[0] & (base_ovf | (pow_mul[2*OUTW-1:OUTW] != '0)));

`ifdef ARITH_SQRT_EN
  // Digit-by-digit square root: bring down two radicand bits, try 4*root+1.
  assign sq_sh      = (div_rem << 2) | {{(WIDTH-1){1'b0}}, acc_a[WIDTH-1:WIDTH-2]};
  assign sq_trial   = ({1'b0, acc_q} << 2) | {{(WIDTH-1){1'b0}}, 2'b01};
  assign sq_ge      = (sq_sh >= sq_trial);
  assign sq_rem_nxt = sq_ge ? (sq_sh - sq_trial) : sq_sh;
  assign root_nxt   = {acc_q[WIDTH-2:0], sq_ge};
`endif

  // Value written to result/err on the final CALC iteration.
  always_comb begin
    calc_result = '0;
    calc_err    = 1'b0;
    case (op_q)
      OP_SUM: calc_result = a_ext + b_ext;
      OP_SUB: calc_result = a_ext - b_ext;
      OP_MUL: calc_result = a_ext * b_ext;
      OP_DIV: begin
        if (acc_b == '0) begin
          calc_result = '1;
          calc_err    = 1'b1;
        end else begin
          calc_result = {div_rem_nxt[WIDTH-1:0], quot_nxt};
        end
      end
`ifdef ARITH_SQRT_EN
      OP_SQRT: calc_result = {{(OUTW-WIDTH){1'b0}}, root_nxt};
`endif
      OP_POW: begin
        calc_result = pow_res_nxt;
        calc_err    = err_acc_nxt;
      end
      default: calc_err = 1'b1;
    endcase
  end

  // FSM next state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == FIN);
    case (state)
      IDLE: if (start) state_nxt = CALC;
      CALC: if (last_iter) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, operand latches and iterative datapath.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      op_q     <= '0;
      acc_a    <= '0;
      acc_b    <= '0;
      div_rem  <= '0;
      pow_res  <= '0;
      pow_base <= '0;
      base_ovf <= 1'b0;
      err_acc  <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      err      <= 1'b0;
`ifdef ARITH_SQRT_EN
      acc_q    <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= opcode;
            acc_a    <= a;
            acc_b    <= b;
            div_rem  <= '0;
            pow_res  <= {{(OUTW-1){1'b0}}, 1'b1};
            pow_base <= {{(OUTW-WIDTH){1'b0}}, a};
            base_ovf <= 1'b0;
            err_acc  <= 1'b0;
`ifdef ARITH_SQRT_EN
            acc_q    <= '0;
`endif
            case (opcode)
              OP_DIV:  cnt <= (b == '0) ? '0 : CNT_FULL;
              OP_POW:  cnt <= CNT_FULL;
`ifdef ARITH_SQRT_EN
              OP_SQRT: cnt <= CNT_HALF;
`endif
              default: cnt <= '0;
            endcase
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          case (op_q)
            OP_DIV: begin
              acc_a   <= quot_nxt;
              div_rem <= div_rem_nxt;
            end
`ifdef ARITH_SQRT_EN
            OP_SQRT: begin
              acc_a   <= acc_a << 2;
              div_rem <= sq_rem_nxt;
              acc_q   <= root_nxt;
            end
`endif
            OP_POW: begin
              acc_b    <= acc_b >> 1;
              pow_res  <= pow_res_nxt;
              pow_base <= pow_sq[OUTW-1:0];
              base_ovf <= base_ovf_nxt;
              err_acc  <= err_acc_nxt;
            end
            default: ;
          endcase
          if (last_iter) begin
            result <= calc_result;
            err    <= calc_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_seq.sv
// tb_arith_seq -- self-checking bench for arith_seq (WIDTH=32).
// Directed cases plus randomized operations, each compared against a
// behavioural model built from plain arithmetic. SQRT expectations follow
// ARITH_SQRT_EN.

module tb_arith_seq;

  localparam int WIDTH = 32;
  localparam int OUTW  = 64;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, err;
  logic [OUTW-1:0]  result;

  int tests = 0;
  int fails = 0;

  arith_seq #(.WIDTH(WIDTH), .OUTW(OUTW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .opcode(opcode), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

`ifdef ARITH_SQRT_EN
  function automatic logic [63:0] isqrt(input logic [31:0] x);
    logic [63:0] lo, hi, mid;
    lo = 0;
    hi = 64'd65536;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= {32'd0, x}) lo = mid;
      else hi = mid;
    end
    return lo;
  endfunction
`endif

  // Expected result, error flag and accept->done latency in cycles.
  function automatic void model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] r, output logic e, output int lat);
    logic [127:0] acc;
    r = '0;
    e = 1'b0;
    lat = 2;
    case (op)
      4'd0: r = 64'(x) + 64'(y);
      4'd1: r = 64'(x) - 64'(y);
      4'd2: r = 64'(x) * 64'(y);
      4'd3: begin
        if (y == 0) begin
          r = '1;
          e = 1'b1;
        end else begin
          r = {x % y, x / y};
          lat = 33;
        end
      end
      4'd4: begin
`ifdef ARITH_SQRT_EN
        r = isqrt(x);
        lat = 17;
`else
        e = 1'b1;
`endif
      end
      4'd5: begin
        lat = 33;
        acc = 128'd1;
        for (int i = 0; i < int'(y); i++) begin
          acc = {64'd0, acc[63:0]} * {96'd0, x};
          if (acc[127:64] != 0) e = 1'b1;
        end
        r = acc[63:0];
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic check_output(input string tag, input logic [63:0] er, input logic ee,
                              input int el, input int cyc);
    check({tag, "/latency"}, 64'(cyc), 64'(el));
    check({tag, "/result"}, result, er);
    check({tag, "/err"}, {63'd0, err}, {63'd0, ee});
  endtask

  // One complete operation; operands are scrambled after accept to show latching.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                input string tag);
    logic [63:0] er;
    logic ee;
    int el, cyc;
    model(op, x, y, er, ee, el);
    @(negedge CLK);
    start = 1'b1;
    opcode = op;
    a = x;
    b = y;
    @(negedge CLK);
    start = 1'b0;
    opcode = 4'($urandom);
    a = $urandom;
    b = $urandom;
    check({tag, "/busy1"}, {63'd0, busy}, 64'd1);
    cyc = 1;
    while (!done && cyc < 100) begin
      @(negedge CLK);
      cyc++;
    end
    check_output(tag, er, ee, el, cyc);
    @(negedge CLK);
    check({tag, "/idle"}, {62'd0, busy, done}, 64'd0);
    check({tag, "/held"}, result, er);
  endtask

  initial begin
    logic [3:0] rop;
    logic [31:0] rx, ry;

    RST = 1'b1;
    start = 1'b1;
    opcode = 4'd0;
    a = 32'd1;
    b = 32'd2;
    repeat (3) @(negedge CLK);
    check("reset/busy", {63'd0, busy}, 64'd0);
    check("reset/done", {63'd0, done}, 64'd0);
    check("reset/result", result, 64'd0);
    check("reset/err", {63'd0, err}, 64'd0);
    RST = 1'b0;
    start = 1'b0;

    apply_stimulus(4'd0, 32'd15, 32'd10, "sum15_10");
    apply_stimulus(4'd1, 32'd10, 32'd25, "sub10_25");
    apply_stimulus(4'd0, 32'hFFFF_FFFF, 32'd1, "sum_carry");
    apply_stimulus(4'd3, 32'd100, 32'd7, "div100_7");
    apply_stimulus(4'd3, 32'd100, 32'd0, "div_by0");
    apply_stimulus(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    apply_stimulus(4'd5, 32'd2, 32'd3, "pow2_3");
    apply_stimulus(4'd5, 32'd2, 32'd64, "pow2_64");
    apply_stimulus(4'd5, 32'd0, 32'd0, "pow0_0");
    apply_stimulus(4'd4, 32'd16, 32'd0, "sqrt16");
    apply_stimulus(4'd4, 32'hFFFF_FFFF, 32'd0, "sqrt_max");
    apply_stimulus(4'd9, 32'd3, 32'd4, "undef_op");

    // Start during the done cycle is ignored; the following cycle accepts.
    @(negedge CLK);
    start = 1'b1; opcode = 4'd0; a = 32'd15; b = 32'd10;
    @(negedge CLK);
    start = 1'b0;
    @(negedge CLK);
    check("fin/done", {63'd0, done}, 64'd1);
    start = 1'b1; opcode = 4'd0; a = 32'd3; b = 32'd4;
    @(negedge CLK);
    check("fin/ignored", {63'd0, busy}, 64'd0);
    @(negedge CLK);
    start = 1'b0;
    check("fin/accept", {63'd0, busy}, 64'd1);
    @(negedge CLK);
    check("fin/done2", {63'd0, done}, 64'd1);
    check("fin/result2", result, 64'd7);

    // DIV aborted by reset after an ignored mid-operation start.
    @(negedge CLK);
    start = 1'b1; opcode = 4'd3; a = 32'd100; b = 32'd7;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(negedge CLK);
      start = (c == 5);
      if (c == 5) begin
        opcode = 4'd0; a = 32'd1; b = 32'd1;
      end
      check($sformatf("abort/busy_c%0d", c), {62'd0, busy, done}, 64'd2);
      if (c == 10) RST = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b0;
    start = 1'b0;
    check("abort/outs", {busy, done, err, result[60:0]}, 64'd0);
    begin
      int seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge CLK);
        if (done || busy) seen++;
      end
      check("abort/no_done", 64'(seen), 64'd0);
    end
    apply_stimulus(4'd3, 32'd100, 32'd7, "after_abort");

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
      rx = $urandom;
      ry = $urandom;
      case (rop)
        4'd3: if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 15);
        4'd4: if ($urandom_range(0, 1) == 0) rx = $urandom_range(0, 300);
        4'd5: begin
          if ($urandom_range(0, 1) == 0) rx = $urandom_range(0, 20);
          ry = $urandom_range(0, 80);
        end
        default: ;
      endcase
      apply_stimulus(rop, rx, ry, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
